// File: rtl/wrapper_digits10.sv
// wrapper_digits10: raster sync generator plus a digit-glyph renderer.
// Draws the digits 0..9 as 5x5 bitmaps (each glyph pixel 2x2 screen pixels) in 16x16
// cells across a 256x240 screen; the cell row repeats every 16 lines.
// One pixel lasts two clk cycles.
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous, active-high
//   keys   in   [2:0] foreground colour (0 selects FG_DEFAULT), [3] inverts the picture
//   hsync  out  horizontal sync, active low
//   vsync  out  vertical sync, active low
//   rgb    out  {R,G,B}, 0 outside the visible area
module wrapper_digits10 #(
    parameter int unsigned H_DISPLAY  = 256,
    parameter int unsigned H_FRONT    = 7,
    parameter int unsigned H_SYNC     = 23,
    parameter int unsigned H_BACK     = 23,
    parameter int unsigned V_DISPLAY  = 240,
    parameter int unsigned V_BOTTOM   = 14,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_TOP      = 5,
    parameter logic [2:0]  FG_DEFAULT = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keys,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam logic [8:0] H_VIS      = 9'(H_DISPLAY);
    localparam logic [8:0] H_SYNC_BEG = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] H_SYNC_END = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] H_LAST     = 9'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [8:0] V_VIS      = 9'(V_DISPLAY);
    localparam logic [8:0] V_SYNC_BEG = 9'(V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] V_SYNC_END = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [8:0] V_LAST     = 9'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);

    logic       pix_en_q, pix_en_d;
    logic [8:0] hpos_q, hpos_d;
    logic [8:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [2:0] rgb_q, rgb_d;

    logic [3:0]  digit;
    logic [2:0]  xofs;
    logic [2:0]  yofs;
    logic [24:0] glyph;
    logic [4:0]  glyph_row;
    logic        lit;
    logic        display_on;
    logic [2:0]  fg;

    assign digit = hpos_q[7:4];
    assign xofs  = hpos_q[3:1];
    assign yofs  = vpos_q[3:1];

    // Glyph ROM: five 5-bit rows packed top row first, MSB = leftmost pixel.
    always_comb begin
        glyph = '0;
        case (digit)
            4'd0:    glyph = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h1F};
            4'd1:    glyph = {5'h0C, 5'h04, 5'h04, 5'h04, 5'h1F};
            4'd2:    glyph = {5'h1F, 5'h01, 5'h1F, 5'h10, 5'h1F};
            4'd3:    glyph = {5'h1F, 5'h01, 5'h1F, 5'h01, 5'h1F};
            4'd4:    glyph = {5'h11, 5'h11, 5'h1F, 5'h01, 5'h01};
            4'd5:    glyph = {5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F};
            4'd6:    glyph = {5'h1F, 5'h10, 5'h1F, 5'h11, 5'h1F};
            4'd7:    glyph = {5'h1F, 5'h01, 5'h01, 5'h01, 5'h01};
            4'd8:    glyph = {5'h1F, 5'h11, 5'h1F, 5'h11, 5'h1F};
            4'd9:    glyph = {5'h1F, 5'h11, 5'h1F, 5'h01, 5'h1F};
            default: glyph = '0;
        endcase
    end

    always_comb begin
        glyph_row = '0;
        case (yofs)
            3'd0:    glyph_row = glyph[24:20];
            3'd1:    glyph_row = glyph[19:15];
            3'd2:    glyph_row = glyph[14:10];
            3'd3:    glyph_row = glyph[9:5];
            3'd4:    glyph_row = glyph[4:0];
            default: glyph_row = '0;
        endcase
    end

    // The mask shifts out entirely for xofs 5..7, leaving those columns blank.
    assign lit        = |(glyph_row & (5'b10000 >> xofs));
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign fg         = (keys[2:0] == 3'd0) ? FG_DEFAULT : keys[2:0];

    always_comb begin
        pix_en_d = ~pix_en_q;
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        if (pix_en_q) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? 9'd0 : vpos_q + 9'd1;
            end else begin
                hpos_d = hpos_q + 9'd1;
            end
        end
        hsync_d = !((hpos_q >= H_SYNC_BEG) && (hpos_q <= H_SYNC_END));
        vsync_d = !((vpos_q >= V_SYNC_BEG) && (vpos_q <= V_SYNC_END));
        rgb_d   = (display_on && (lit ^ keys[3])) ? fg : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en_q <= 1'b0;
            hpos_q   <= '0;
            vpos_q   <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= 3'b000;
        end else begin
            pix_en_q <= pix_en_d;
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_wrapper_digits10.sv
// Bench for wrapper_digits10. A second instance with a short vertical timing lets whole
// frames, and thus vsync width and period, fit in a short run.
module tb_wrapper_digits10;

    localparam int V2_DISPLAY = 20;
    localparam int V2_BOTTOM  = 3;
    localparam int V2_SYNC    = 3;
    localparam int V2_TOP     = 2;
    localparam int V2_LINES   = V2_DISPLAY + V2_BOTTOM + V2_SYNC + V2_TOP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys = 4'd0;
    logic       hs1, vs1, hs2, vs2;
    logic [2:0] rgb1, rgb2;

    always #5 clk = ~clk;

    wrapper_digits10 dut1 (
        .clk   (clk),
        .reset (reset),
        .keys  (keys),
        .hsync (hs1),
        .vsync (vs1),
        .rgb   (rgb1)
    );

    wrapper_digits10 #(
        .V_DISPLAY (V2_DISPLAY),
        .V_BOTTOM  (V2_BOTTOM),
        .V_SYNC    (V2_SYNC),
        .V_TOP     (V2_TOP)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .keys  (keys),
        .hsync (hs2),
        .vsync (vs2),
        .rgb   (rgb2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, got, exp, $time);
        end
    endtask

    logic [4:0] rom [10][5] = '{
        '{5'h1F, 5'h11, 5'h11, 5'h11, 5'h1F},
        '{5'h0C, 5'h04, 5'h04, 5'h04, 5'h1F},
        '{5'h1F, 5'h01, 5'h1F, 5'h10, 5'h1F},
        '{5'h1F, 5'h01, 5'h1F, 5'h01, 5'h1F},
        '{5'h11, 5'h11, 5'h1F, 5'h01, 5'h01},
        '{5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F},
        '{5'h1F, 5'h10, 5'h1F, 5'h11, 5'h1F},
        '{5'h1F, 5'h01, 5'h01, 5'h01, 5'h01},
        '{5'h1F, 5'h11, 5'h1F, 5'h11, 5'h1F},
        '{5'h1F, 5'h11, 5'h1F, 5'h01, 5'h1F}
    };

    // Expected {hsync, vsync, rgb} after the cc-th clk edge since the last reset edge,
    // with keys k sampled at that edge. Each pixel lasts 2 clk; outputs lag by 1 clk.
    function automatic logic [4:0] model(input int cc, input logic [3:0] k, input int vlines,
                                         input int vdisp, input int vsbeg);
        int p, h, v, d, x, y;
        logic lit, px, hs, vs;
        logic [2:0] fg, col;
        p   = (cc - 1) / 2;
        h   = p % 309;
        v   = (p / 309) % vlines;
        hs  = !(h >= 263 && h <= 285);
        vs  = !(v >= vsbeg && v <= vsbeg + 2);
        d   = h / 16;
        x   = (h % 16) / 2;
        y   = (v % 16) / 2;
        lit = 1'b0;
        if (d < 10 && x < 5 && y < 5) lit = rom[d][y][4 - x];
        fg  = (k[2:0] == 3'd0) ? 3'd2 : k[2:0];
        px  = lit ^ k[3];
        col = (h < 256 && v < vdisp && px) ? fg : 3'd0;
        return {hs, vs, col};
    endfunction

    // Edges since the last reset edge, plus keys/reset as seen by that edge.
    int         c = 0;
    int         cyc = 0;
    logic [3:0] kq = 4'd0;
    logic       rq = 1'b1;
    bit         started = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        kq  <= keys;
        rq  <= reset;
        if (reset) begin
            c       <= 0;
            started <= 1'b1;
        end else begin
            c <= c + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, plus sync width/period measurement.
    int n_hs_period = 0;
    int n_vs_period = 0;
    initial begin
        logic [4:0] e1, e2;
        logic hs_prev, vs_prev;
        bit   hs_have, vs_have_fall, vs_have_rise;
        int   hs_fall, vs_fall, vs_rise;
        hs_prev = 1'b1; vs_prev = 1'b1;
        hs_have = 1'b0; vs_have_fall = 1'b0; vs_have_rise = 1'b0;
        hs_fall = 0; vs_fall = 0; vs_rise = 0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (rq) begin
                    e1 = 5'b11000;
                    e2 = 5'b11000;
                    hs_have = 1'b0; vs_have_fall = 1'b0; vs_have_rise = 1'b0;
                end else begin
                    e1 = model(c, kq, 262, 240, 254);
                    e2 = model(c, kq, V2_LINES, V2_DISPLAY, V2_DISPLAY + V2_BOTTOM);
                    if (hs_prev && !hs1) begin
                        if (hs_have) begin
                            check("hsync period", 32'(cyc - hs_fall), 32'd618);
                            n_hs_period++;
                        end
                        hs_fall = cyc;
                        hs_have = 1'b1;
                    end
                    if (!hs_prev && hs1 && hs_have)
                        check("hsync low width", 32'(cyc - hs_fall), 32'd46);
                    if (vs_prev && !vs2) begin
                        vs_fall = cyc;
                        vs_have_fall = 1'b1;
                    end
                    if (!vs_prev && vs2) begin
                        if (vs_have_fall)
                            check("vsync low width", 32'(cyc - vs_fall), 32'd1854);
                        if (vs_have_rise) begin
                            check("vsync rise period", 32'(cyc - vs_rise), 32'(V2_LINES * 618));
                            n_vs_period++;
                        end
                        vs_rise = cyc;
                        vs_have_rise = 1'b1;
                    end
                end
                check("dut1 {hs,vs,rgb}", 32'({hs1, vs1, rgb1}), 32'(e1));
                check("dut2 {hs,vs,rgb}", 32'({hs2, vs2, rgb2}), 32'(e2));
            end
            hs_prev = hs1;
            vs_prev = vs2;
        end
    end

    typedef struct {
        int         v;
        int         h;
        logic [3:0] k;
        logic [2:0] rgb;
        logic       hs;
    } vec_t;

    vec_t tbl [27];

    initial begin
        int guard, cc, n;
        tbl = '{
            '{0, 0, 4'd0, 3'd2, 1'b1},   '{0, 5, 4'd0, 3'd2, 1'b1},   '{0, 9, 4'd0, 3'd2, 1'b1},
            '{0, 10, 4'd0, 3'd0, 1'b1},  '{0, 15, 4'd0, 3'd0, 1'b1},  '{0, 17, 4'd0, 3'd0, 1'b1},
            '{0, 18, 4'd0, 3'd2, 1'b1},  '{0, 21, 4'd0, 3'd2, 1'b1},  '{0, 22, 4'd0, 3'd0, 1'b1},
            '{0, 160, 4'd0, 3'd0, 1'b1}, '{0, 255, 4'd0, 3'd0, 1'b1}, '{0, 262, 4'd0, 3'd0, 1'b1},
            '{0, 263, 4'd0, 3'd0, 1'b0}, '{0, 285, 4'd0, 3'd0, 1'b0}, '{0, 286, 4'd0, 3'd0, 1'b1},
            '{2, 19, 4'd0, 3'd0, 1'b1},  '{2, 20, 4'd0, 3'd2, 1'b1},  '{2, 21, 4'd0, 3'd2, 1'b1},
            '{2, 22, 4'd0, 3'd0, 1'b1},
            '{4, 18, 4'd5, 3'd0, 1'b1},  '{4, 20, 4'd5, 3'd5, 1'b1},  '{4, 32, 4'd5, 3'd5, 1'b1},
            '{4, 300, 4'd5, 3'd0, 1'b1},
            '{6, 0, 4'd8, 3'd0, 1'b1},   '{6, 2, 4'd8, 3'd2, 1'b1},   '{6, 170, 4'd8, 3'd2, 1'b1},
            '{6, 270, 4'd8, 3'd0, 1'b0}
        };

        reset = 1'b1;
        keys  = 4'd0;
        repeat (7) @(negedge clk);
        check("reset hsync", 32'(hs1), 32'd1);
        check("reset vsync", 32'(vs1), 32'd1);
        check("reset rgb", 32'(rgb1), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            cc = 2 * (tbl[i].v * 309 + tbl[i].h) + 1;
            guard = 0;
            while (c < cc - 1 && guard < 20000) begin
                @(negedge clk);
                guard++;
            end
            check("table position reached", 32'(c), 32'(cc - 1));
            keys = tbl[i].k;
            @(negedge clk);
            check($sformatf("table rgb v%0d h%0d", tbl[i].v, tbl[i].h), 32'(rgb1),
                  32'(tbl[i].rgb));
            check($sformatf("table hsync v%0d h%0d", tbl[i].v, tbl[i].h), 32'(hs1),
                  32'(tbl[i].hs));
        end

        // One-cycle reset in the middle of a line, inside the hsync pulse.
        reset = 1'b1;
        @(negedge clk);
        check("mid reset hsync", 32'(hs1), 32'd1);
        check("mid reset vsync", 32'(vs1), 32'd1);
        check("mid reset rgb", 32'(rgb1), 32'd0);
        reset = 1'b0;
        keys  = 4'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hs1 && n < 2000);
        // Pixel 263 is reached after 526 edges, then the output register adds one.
        check("hsync fall after reset", 32'(n), 32'd527);

        repeat (36000) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) keys = 4'($urandom);
        end

        check("hsync periods observed", 32'(n_hs_period > 10), 32'd1);
        check("vsync periods observed", 32'(n_vs_period > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
